lc3_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single LC-3 memory port. The CPU controller's MAR/MDR memory accesses and a loader/debug port (program preload, memory inspection) share one synchronous memory. The block latches the winning request, issues exactly one memory cycle, returns read data, and acknowledges the owner. It sits between the LC-3 datapath/controller, the loader, and the memory model.

---
 rtl/lc3_mem_arbiter.sv | 95 +++++++++
 tb/tb_lc3_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: arbitrates CPU and loader requests onto one synchronous LC-3 memory port,
// issuing one memory cycle per grant and acknowledging the owner.
module lc3_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CPU_PRIORITY = 1,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;
  state_t state;
  logic prev, lock_flag, lock_ok, pick_ldr;
  logic [CW-1:0] lock_cnt;
  always_comb begin
    lock_ok = prev && lock_flag && lock_cnt < CW'(LOCK_MAX);
    pick_ldr = ldr_req && (!cpu_req || lock_ok || (CPU_PRIORITY == 0 && !prev));
  end
  assign busy = state != IDLE;
  // mem_* registers double as the latched request; they are cleared once ISSUE ends
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      prev <= 1'b1;
      lock_flag <= 1'b0;
      lock_cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else
      case (state)
        IDLE: if (cpu_req || ldr_req) begin
          state <= ISSUE;
          owner <= pick_ldr;
          prev <= pick_ldr;
          lock_flag <= pick_ldr && ldr_lock;
          lock_cnt <= (pick_ldr && cpu_req && lock_ok) ? lock_cnt + 1'b1 : '0;
          mem_en <= 1'b1;
          mem_we <= pick_ldr ? ldr_we : cpu_we;
          mem_addr <= pick_ldr ? ldr_addr : cpu_addr;
          mem_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
        end
        ISSUE: begin
          state <= mem_we ? ACK : RDWAIT;
          cpu_ack <= mem_we && !owner;
          ldr_ack <= mem_we && owner;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          mem_addr <= '0;
          mem_wdata <= '0;
        end
        RDWAIT: begin
          state <= ACK;
          cpu_ack <= !owner;
          ldr_ack <= owner;
          cpu_rdata <= owner ? '0 : mem_rdata;
          ldr_rdata <= owner ? mem_rdata : '0;
        end
        ACK: begin
          state <= IDLE;
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          cpu_rdata <= '0;
          ldr_rdata <= '0;
        end
      endcase
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: table-driven cycle vectors plus directed multi-cycle sequences
// against a CPU-priority instance and a round-robin instance.
module tb_lc3_mem_arbiter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic creq, cwe, lreq, lwe, llock;
  logic [15:0] caddr, cwd, laddr, lwd;
  logic en, we, cack, lack, busy, owner;
  logic [15:0] addr, wd, crd, lrd, rdata;
  logic r_en, r_we, r_cack, r_lack, r_busy, r_owner;
  logic [15:0] r_addr, r_wd, r_crd, r_lrd, r_rdata;
  logic [15:0] mem [256];
  logic [15:0] r_mem [256];
  // word 0 (address 0x3000 aliases here) is preloaded with 0x1234 while reset is high
  always @(posedge clk) begin
    if (rst) mem[0] <= 16'h1234;
    else if (en && we) mem[addr[7:0]] <= wd;
    rdata <= mem[addr[7:0]];
  end
  always @(posedge clk) begin
    if (rst) r_mem[0] <= 16'h1234;
    else if (r_en && r_we) r_mem[r_addr[7:0]] <= r_wd;
    r_rdata <= r_mem[r_addr[7:0]];
  end
  lc3_mem_arbiter #(.CPU_PRIORITY(1), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(creq), .cpu_we(cwe), .cpu_addr(caddr), .cpu_wdata(cwd),
    .ldr_req(lreq), .ldr_we(lwe), .ldr_addr(laddr), .ldr_wdata(lwd), .ldr_lock(llock),
    .cpu_ack(cack), .cpu_rdata(crd), .ldr_ack(lack), .ldr_rdata(lrd),
    .mem_en(en), .mem_we(we), .mem_addr(addr), .mem_wdata(wd), .mem_rdata(rdata),
    .busy(busy), .owner(owner));
  lc3_mem_arbiter #(.CPU_PRIORITY(0), .LOCK_MAX(4)) dut_rr (
    .clk(clk), .rst(rst), .cpu_req(creq), .cpu_we(cwe), .cpu_addr(caddr), .cpu_wdata(cwd),
    .ldr_req(lreq), .ldr_we(lwe), .ldr_addr(laddr), .ldr_wdata(lwd), .ldr_lock(llock),
    .cpu_ack(r_cack), .cpu_rdata(r_crd), .ldr_ack(r_lack), .ldr_rdata(r_lrd),
    .mem_en(r_en), .mem_we(r_we), .mem_addr(r_addr), .mem_wdata(r_wd), .mem_rdata(r_rdata),
    .busy(r_busy), .owner(r_owner));
  typedef struct {
    logic creq, cwe, lreq, lwe, llock;
    logic [15:0] caddr, cwd, laddr, lwd;
    logic en, we, cack, lack, busy, owner;
    logic [15:0] addr, wd, crd, lrd;
  } vec_t;
  vec_t tbl[$];
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic add(input logic cq, cw, input logic [15:0] ca, cd, input logic lq, lw,
                     input logic [15:0] la, ld, input logic lk, e, w, input logic [15:0] a, d,
                     input logic ck, input logic [15:0] cr, input logic lak,
                     input logic [15:0] lr, input logic b, o);
    vec_t v;
    v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
    v.lreq = lq; v.lwe = lw; v.laddr = la; v.lwd = ld; v.llock = lk;
    v.en = e; v.we = w; v.addr = a; v.wd = d;
    v.cack = ck; v.crd = cr; v.lack = lak; v.lrd = lr; v.busy = b; v.owner = o;
    tbl.push_back(v);
  endtask
  function automatic logic [127:0] outs();
    return {58'd0, en, we, addr, wd, cack, crd, lack, lrd, busy, owner};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    creq = 0; cwe = 0; caddr = 0; cwd = 0;
    lreq = 0; lwe = 0; laddr = 0; lwd = 0; llock = 0;
  endtask
  task automatic do_reset();
    clr();
    rst = 1;
    step();
    rst = 0;
  endtask
  logic g [6];
  logic [2:0] cnt [6];
  int n;
  initial begin
    clr();
    // CPU read alone: word 0x1234 at 0x3000, ack+rdata in cycle 3
    add(1,0,16'h3000,0, 0,0,0,0,0, 0,0,0,0,         0,0,0,0,                1,0);
    tbl[0].busy = 0;
    add(1,0,16'h3000,0, 0,0,0,0,0, 1,0,16'h3000,0,  0,0,0,0,                1,0);
    add(1,0,16'h3000,0, 0,0,0,0,0, 0,0,0,0,         0,0,0,0,                1,0);
    add(1,0,16'h3000,0, 0,0,0,0,0, 0,0,0,0,         1,16'h1234,0,0,         1,0);
    add(0,0,0,0,        0,0,0,0,0, 0,0,0,0,         0,0,0,0,                0,0);
    // simultaneous writes, CPU first, loader issued at cycle 4
    add(1,1,16'h10,16'hAAAA, 1,1,16'h20,16'h5555,0, 0,0,0,0,             0,0,0,0, 0,0);
    add(1,1,16'h10,16'hAAAA, 1,1,16'h20,16'h5555,0, 1,1,16'h10,16'hAAAA, 0,0,0,0, 1,0);
    add(1,1,16'h10,16'hAAAA, 1,1,16'h20,16'h5555,0, 0,0,0,0,             1,0,0,0, 1,0);
    add(0,0,0,0,             1,1,16'h20,16'h5555,0, 0,0,0,0,             0,0,0,0, 0,0);
    add(0,0,0,0,             1,1,16'h20,16'h5555,0, 1,1,16'h20,16'h5555, 0,0,0,0, 1,1);
    add(0,0,0,0,             1,1,16'h20,16'h5555,0, 0,0,0,0,             0,0,1,0, 1,1);
    // loader reads back the CPU's word
    add(0,0,0,0, 1,0,16'h10,0,0, 0,0,0,0,       0,0,0,0,          0,1);
    add(0,0,0,0, 1,0,16'h10,0,0, 1,0,16'h10,0,  0,0,0,0,          1,1);
    add(0,0,0,0, 1,0,16'h10,0,0, 0,0,0,0,       0,0,0,0,          1,1);
    add(0,0,0,0, 1,0,16'h10,0,0, 0,0,0,0,       0,0,1,16'hAAAA,   1,1);
    add(0,0,0,0, 0,0,0,0,0,      0,0,0,0,       0,0,0,0,          0,1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", outs(), 128'd0);
    chk("reset lock_cnt", 128'(dut.lock_cnt), 128'd0);
    rst = 0;
    foreach (tbl[i]) begin
      creq = tbl[i].creq; cwe = tbl[i].cwe; caddr = tbl[i].caddr; cwd = tbl[i].cwd;
      lreq = tbl[i].lreq; lwe = tbl[i].lwe; laddr = tbl[i].laddr; lwd = tbl[i].lwd;
      llock = tbl[i].llock;
      #1;
      chk($sformatf("vec%0d", i), outs(), {58'd0, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wd,
          tbl[i].cack, tbl[i].crd, tbl[i].lack, tbl[i].lrd, tbl[i].busy, tbl[i].owner});
      step();
    end
    // round-robin instance: continuous reads from both sides
    do_reset();
    creq = 1; caddr = 16'h10; lreq = 1; laddr = 16'h20;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      if (r_en) begin g[n] = r_owner; n++; end
      step();
    end
    chk("rr grant count", 128'(n), 128'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr grant%0d", k), 128'(g[k]), 128'(k % 2));
    // lock guard: loader locked writes, CPU pending from the first loader grant
    do_reset();
    lreq = 1; lwe = 1; laddr = 16'h30; lwd = 16'h7; llock = 1;
    step();
    creq = 1; caddr = 16'h3000;
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      if (en) begin g[n] = owner; cnt[n] = dut.lock_cnt; n++; end
      step();
    end
    chk("lock grant count", 128'(n), 128'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("lock owner%0d", k), 128'(g[k]), 128'(k < 5));
      chk($sformatf("lock cnt%0d", k), 128'(cnt[k]), 128'(k < 5 ? k : 0));
    end
    // reset during a loader read in RDWAIT
    do_reset();
    lreq = 1; laddr = 16'h10;
    step();
    step();
    chk("rdwait busy/owner", {busy, owner, en}, 128'b110);
    rst = 1;
    #1;
    chk("reset mid-read", outs(), 128'd0);
    clr();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("no ack in reset %0d", k), {cack, lack, en, busy}, 128'd0);
    end
    rst = 0;
    creq = 1; caddr = 16'h3000;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post-reset read c%0d", k), {cack, lack, crd},
          {1'b0, k == 3, 1'b0, k == 3 ? 16'h1234 : 16'h0});
      if (k == 3) creq = 0;
      step();
    end
    // address change after latch is ignored until the next IDLE
    creq = 1; caddr = 16'h40;
    step();
    caddr = 16'h41;
    #1;
    chk("latched addr", {en, addr}, {1'b1, 16'h40});
    step();
    chk("no reissue c2", {en, cack}, 128'd0);
    step();
    chk("ack c3", {en, cack}, 128'b01);
    step();
    chk("idle c4", {en, busy}, 128'd0);
    step();
    chk("new issue c5", {en, addr}, {1'b1, 16'h41});
    clr();
    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
